// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings
// and a small clog2 helper.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One pipeline slice: conditionally shifts by STEP in the selected mode and
// registers valid/data/mode/shamt, holding everything while stalled.
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [SHW-1:0]   in_shamt,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q,
  output logic [1:0]       mode_q,
  output logic [SHW-1:0]   shamt_q
);

  localparam int BIT = clog2(STEP);

  logic [WIDTH-1:0] shifted;
  logic             vld_d;
  logic [WIDTH-1:0] data_d;
  logic [1:0]       mode_d;
  logic [SHW-1:0]   shamt_d;

  // ASR fills from the current MSB, which every earlier stage has preserved.
  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
      case (in_mode)
        MODE_LSL: shifted = in_data << STEP;
        MODE_LSR: shifted = in_data >> STEP;
        MODE_ASR: shifted = WIDTH'($signed(in_data) >>> STEP);
        default:  shifted = (in_data >> STEP) | (in_data << (WIDTH - STEP));
      endcase
    end
  end

  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    if (adv) begin
      vld_d   = in_valid;
      data_d  = shifted;
      mode_d  = in_mode;
      shamt_d = in_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Elastic barrel shifter: one registered stage per shift-amount bit, so
// latency is log2(WIDTH) cycles with one operation per cycle throughput.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic [SHW-1:0]            vld;
  logic [SHW-1:0][WIDTH-1:0] data;
  logic [SHW-1:0][1:0]       mode;
  logic [SHW-1:0][SHW-1:0]   shamt;
  logic [SHW:0]              adv;
  logic                      unused_shamt;

  // A stage advances when empty or when its successor advances; the chain
  // is purely combinational back from out_ready.
  always_comb begin
    adv      = '0;
    adv[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) adv[k] = !vld[k] || adv[k+1];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             s_vld;
    logic [WIDTH-1:0] s_data;
    logic [1:0]       s_mode;
    logic [SHW-1:0]   s_shamt;

    if (k == 0) begin : g_src_in
      assign s_vld   = in_valid;
      assign s_data  = in_data;
      assign s_mode  = in_mode;
      assign s_shamt = in_shamt;
    end else begin : g_src_prev
      assign s_vld   = vld[k-1];
      assign s_data  = data[k-1];
      assign s_mode  = mode[k-1];
      assign s_shamt = shamt[k-1];
    end

    shift_stage #(.WIDTH(WIDTH), .SHW(SHW), .STEP(1 << k)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv[k]),
      .in_valid (s_vld),
      .in_data  (s_data),
      .in_mode  (s_mode),
      .in_shamt (s_shamt),
      .vld_q    (vld[k]),
      .data_q   (data[k]),
      .mode_q   (mode[k]),
      .shamt_q  (shamt[k])
    );
  end

  assign in_ready     = adv[0];
  assign out_valid    = vld[SHW-1];
  assign out_data     = data[SHW-1];
  assign out_zero     = (data[SHW-1] == '0);
  assign unused_shamt = ^{shamt[SHW-1], mode[SHW-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and random checks of the pipelined barrel shifter at WIDTH=8 and
// WIDTH=32, with an in-order scoreboard fed by a whole-amount shift model.
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [7:0] in_data, out_data;
  logic [2:0] in_shamt;
  logic [1:0] in_mode;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_zero;
  logic [31:0] s_in_data, s_out_data;
  logic [4:0]  s_in_shamt;
  logic [1:0]  s_in_mode;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int s_out_cnt = 0;
  logic [31:0] q8[$];
  logic [31:0] q32[$];
  logic [7:0]  got8[$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_shamt(s_in_shamt), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_zero(s_out_zero)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input int sh,
                                        input logic [1:0] m, input int w);
    logic [31:0] mask, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    d = d & mask;
    case (m)
      2'b00:   r = (d << sh) & mask;
      2'b01:   r = d >> sh;
      2'b10: begin
        r = d >> sh;
        if (d[w-1]) r = r | (mask & ~(mask >> sh));
      end
      default: r = ((d >> sh) | (d << (w - sh))) & mask;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboards: sampled mid-cycle, transfers take effect on the next edge.
  always @(negedge clk) begin
    if (rst) q8.delete();
    else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        got8.push_back(out_data);
        chk("out8_has_input", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) chk("out8_data", 32'(out_data), q8.pop_front());
      end
      if (in_valid && in_ready)
        q8.push_back(model(32'(in_data), int'(in_shamt), in_mode, 8));
    end
  end

  always @(negedge clk) begin
    if (rst) q32.delete();
    else begin
      if (s_out_valid && s_out_ready) begin
        s_out_cnt++;
        chk("out32_has_input", 32'(q32.size() != 0), 32'd1);
        if (q32.size() != 0) begin
          chk("out32_zero", 32'(s_out_zero), 32'(s_out_data == 32'h0));
          chk("out32_data", s_out_data, q32.pop_front());
        end
      end
      if (s_in_valid && s_in_ready)
        q32.push_back(model(s_in_data, int'(s_in_shamt), s_in_mode, 32));
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    do begin
      #1 rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    chk("send_accept", 32'(rdy), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run1(input string tag, input logic [7:0] d, input logic [2:0] s,
                      input logic [1:0] m, input logic [7:0] exp, input logic expz);
    int lat;
    send(d, s, m);
    wait_out(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_zero"}, 32'(out_zero), 32'(expz));
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt0;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h98, 8'hE5, 8'h25, 8'hC0, 8'h5A};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_shamt = '0; s_in_mode = '0;
    s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run1("lsl", 8'hB3, 3'd3, 2'b00, 8'h98, 1'b0);
    run1("asr", 8'h96, 3'd2, 2'b10, 8'hE5, 1'b0);
    run1("lsr", 8'h96, 3'd2, 2'b01, 8'h25, 1'b0);
    run1("ror", 8'h81, 3'd1, 2'b11, 8'hC0, 1'b0);
    run1("lsr_zero", 8'h01, 3'd1, 2'b01, 8'h00, 1'b1);
    run1("shamt0", 8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0);
    run1("asr_max", 8'h80, 3'd7, 2'b10, 8'hFF, 1'b0);

    // Backpressure: fill the pipe, hold, then drain in order.
    got8.delete();
    cnt0 = out_cnt;
    out_ready = 1'b0;
    send(8'hB3, 3'd3, 2'b00);
    send(8'h96, 3'd2, 2'b10);
    send(8'h96, 3'd2, 2'b01);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h98);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(8'h81, 3'd1, 2'b11);
    send(8'h5A, 3'd0, 2'b00);
    for (int i = 0; i < 30 && (q8.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("bp_count", 32'(out_cnt - cnt0), 32'd5);
    chk("bp_got_size", 32'(got8.size()), 32'd5);
    for (int i = 0; i < 5 && i < got8.size(); i++)
      chk("bp_order", 32'(got8[i]), 32'(exp_seq[i]));

    // Reset with two ops in flight: neither may emerge.
    send(8'h0F, 3'd1, 2'b00);
    send(8'hF0, 3'd2, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    cnt0 = out_cnt;
    repeat (8) @(posedge clk);
    #1 chk("rst_mid_no_output", 32'(out_cnt), 32'(cnt0));

    // Random soak on both widths.
    cnt0 = out_cnt;
    for (int i = 0; i < 10000; i++) begin
      in_valid    = 1'($urandom);
      in_data     = 8'($urandom);
      in_shamt    = 3'($urandom);
      in_mode     = 2'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      s_in_valid  = 1'($urandom);
      s_in_data   = $urandom;
      s_in_shamt  = 5'($urandom);
      s_in_mode   = 2'($urandom);
      s_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; s_in_valid = 1'b0;
    out_ready = 1'b1; s_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("soak8_drained", 32'(q8.size()), 32'd0);
    chk("soak32_drained", 32'(q32.size()), 32'd0);
    chk("soak8_activity", 32'(out_cnt - cnt0 > 1000), 32'd1);
    chk("soak32_activity", 32'(s_out_cnt > 1000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
